// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt sequencer that drains the pipeline, commits to CP0 and redirects the PC.
module exc_ctrl #(
  parameter int DRAIN_CYC = 3,
  parameter int INT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exc_sys,
  input  logic             exc_brk,
  input  logic             exc_teq,
  input  logic             exc_eret,
  input  logic [31:0]      exc_pc,
  input  logic [INT_W-1:0] int_req,
  input  logic             int_en,
  input  logic [INT_W-1:0] int_mask,
  output logic             stall,
  output logic             flush,
  output logic             cp0_exception,
  output logic             cp0_eret,
  output logic [4:0]       cp0_cause,
  output logic [31:0]      cp0_pc,
  output logic             pc_redirect,
  output logic [INT_W-1:0] int_ack,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;
  state_t state;
  logic [3:0] cnt;
  logic kind;
  logic [INT_W-1:0] elig, win;
  logic sync_exc, req;
  assign elig = int_req & int_mask & {INT_W{int_en}};
  // isolate the lowest set bit: lowest-index interrupt wins
  assign win = elig & (~elig + 1'b1);
  assign sync_exc = exc_sys | exc_brk | exc_teq;
  assign req = sync_exc | exc_eret | (|elig);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      kind <= 1'b0;
      stall <= 1'b0;
      flush <= 1'b0;
      cp0_exception <= 1'b0;
      cp0_eret <= 1'b0;
      cp0_cause <= '0;
      cp0_pc <= '0;
      pc_redirect <= 1'b0;
      int_ack <= '0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          state <= DRAIN;
          stall <= 1'b1;
          flush <= 1'b1;
          busy <= 1'b1;
          cnt <= 4'(DRAIN_CYC - 1);
          cp0_pc <= exc_pc;
          cp0_cause <= exc_sys ? 5'd8 : exc_brk ? 5'd9 : exc_teq ? 5'd13 : 5'd0;
          kind <= !sync_exc && exc_eret;
          int_ack <= (sync_exc | exc_eret) ? '0 : win;
        end
        DRAIN: begin
          int_ack <= '0;
          if (cnt == 4'd0) begin
            state <= COMMIT;
            flush <= 1'b0;
            cp0_exception <= 1'b1;
            cp0_eret <= kind;
          end else cnt <= cnt - 4'd1;
        end
        COMMIT: begin
          state <= REDIRECT;
          cp0_exception <= 1'b0;
          pc_redirect <= 1'b1;
        end
        default: begin
          state <= IDLE;
          stall <= 1'b0;
          busy <= 1'b0;
          pc_redirect <= 1'b0;
          cp0_eret <= 1'b0;
        end
      endcase
    end
  end
endmodule
